conv_out_framer: RTL and testbench
==================================

// Module: conv_out_framer
// PURPOSE
//  Downstream of conv: consumes the conv result stream (32b signed, valid + accepting backpressure),
//  requantizes each result to 8b (abs or ReLU, arithmetic shift, saturate) and re-inserts the
//  1-pixel border lost by the 3x3 stride-1 window. Emits a full IMG_W x IMG_H 8b frame on a
//  valid/ready stream with SOF/EOL/EOF markers, ready for the next layer or the BMP writer.
// PARAMETERS
//  IMG_W       224  output frame width in pixels (interior width = IMG_W-2)
//  IMG_H       224  output frame height in rows (interior height = IMG_H-2)
//  IN_WIDTH    32   conv result width, signed
//  FIFO_DEPTH  8    result FIFO entries, power of 2, >= 4
//  PAD_VALUE   8'd0 value emitted for border pixels
// PORTS
//  clock         in   1         clock
//  reset         in   1         asynchronous, active-low reset
//  frame_start   in   1         1-cycle pulse: begin emitting one frame (ignored while busy)
//  mode          in   1         0 = abs(result), 1 = ReLU max(result,0); hold stable per frame
//  shift         in   4         arithmetic right shift applied after mode, 0..15
//  in_result     in   IN_WIDTH  conv result (signed)
//  in_valid      in   1         in_result valid this cycle
//  in_accepting  out  1         to conv out_accepting_values; registered
//  out_pixel     out  8         output pixel
//  out_valid     out  1         out_pixel valid
//  out_ready     in   1         downstream accepts when out_valid & out_ready
//  out_sof/eol/eof out 1 each   first pixel of frame / last of row / last of frame, qualify with out_valid
//  busy          out  1         high from cycle after frame_start until EOF handshake completes
//  overflow      out  1         sticky: in_valid seen while FIFO full; cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0 except in_accepting=1; FIFO empty; FSM IDLE; overflow=0.
//  - Requant at FIFO write: v = mode ? max(r,0) : |r|; v >>>= shift; out = (v>255)?255:v.
//    |-2^(IN_WIDTH-1)| saturates to 255. FIFO stores 8b.
//  - FIFO: write on in_valid when not full; in_valid while full -> data dropped, overflow<=1.
//    in_accepting <= (count_next <= FIFO_DEPTH-3) (2-entry skid for conv latency).
//    Results arriving while IDLE are accepted and held for the next frame.
//  - Output register loads when (!out_valid || out_ready); holds pixel+flags stable while stalled.
//  - FSM: IDLE -frame_start-> TOP (IMG_W pad pixels) -> ROW_L (1 pad) -> ROW_BODY (IMG_W-2 FIFO
//    pops) -> ROW_R (1 pad) -> ROW_L while interior rows remain (IMG_H-2 rows total) -> BOTTOM
//    (IMG_W pad) -> IDLE after EOF handshake.
//  - ROW_BODY with FIFO empty: out_valid deasserts (bubble), FSM holds position; no pad inserted.
//  - Simultaneous FIFO write+pop: both occur, count unchanged; pop on empty never happens.
//  - Latency: first TOP pixel out_valid in cycle after frame_start; body pixel visible 1 cycle after
//    pop decision. out_sof on (0,0); out_eol at col IMG_W-1; out_eof at (IMG_W-1,IMG_H-1).
//  - frame_start during busy ignored; reset mid-frame returns to reset state, FIFO flushed.
// CONFIGURATION
//  CONV_FRAMER_CHECKSUM_EN defined: adds output frame_checksum[15:0] = mod-2^16 sum of all pixels
//  emitted in the frame (pads included), updated on the EOF handshake cycle, reset 0.
//  Undefined: port and accumulator absent; all other behaviour identical.
// TESTING
//  1 IMG_W=IMG_H=6, mode=0, shift=0, 16 results all -5, out_ready=1 -> 36 pixels: 20 border=0,
//    16 interior=5; sof at pixel 0, eol every 6th, eof at pixel 35; busy low after.
//  2 Requant: mode=1 in=-7 -> 0; mode=0 in=-7 -> 7; in=1000 shift=2 -> 250; in=1024 shift=2 -> 255;
//    in=32'h8000_0000 mode=0 -> 255.
//  3 out_ready toggled 1-of-3 cycles -> identical pixel sequence as test 1; out_pixel/flags stable
//    whenever out_valid & !out_ready.
//  4 Starve: results delivered 1 per 10 cycles -> out_valid bubbles only in ROW_BODY, no extra pads,
//    36-pixel frame intact.
//  5 Backpressure: in_valid held high, out_ready=0 -> in_accepting falls at count FIFO_DEPTH-2;
//    force in_valid when full -> overflow=1 sticky, dropped value never appears.
//  6 reset low mid-ROW_BODY -> outputs at reset values next edge; new frame_start yields clean frame.

Source files
------------

// File: rtl/conv_out_framer.sv
// conv_out_framer: requantizes the 32b conv result stream to 8b and re-frames it with a 1-pixel pad border.
//
// Ports
//   clock, reset           clock; asynchronous active-low reset
//   frame_start            1-cycle pulse that starts one output frame (ignored while busy)
//   mode, shift            requant controls: 0 = abs, 1 = ReLU; arithmetic right shift 0..15
//   in_result, in_valid    conv result stream
//   in_accepting           registered backpressure to conv, leaves a 2-entry skid
//   out_pixel, out_valid,
//   out_ready              8b pixel stream
//   out_sof/eol/eof        frame markers, qualified by out_valid
//   busy                   frame in progress until the EOF handshake
//   overflow               sticky: a result arrived while the FIFO was full
//   frame_checksum         only with CONV_FRAMER_CHECKSUM_EN: mod-2^16 sum of the last frame's pixels
//
// Optional feature macro: CONV_FRAMER_CHECKSUM_EN
module conv_out_framer #(
  parameter int         IMG_W      = 224,
  parameter int         IMG_H      = 224,
  parameter int         IN_WIDTH   = 32,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] PAD_VALUE  = 8'd0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic                       mode,
  input  logic [3:0]                 shift,
  input  logic signed [IN_WIDTH-1:0] in_result,
  input  logic                       in_valid,
  output logic                       in_accepting,
  output logic [7:0]                 out_pixel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sof,
  output logic                       out_eol,
  output logic                       out_eof,
  output logic                       busy,
  output logic                       overflow
`ifdef CONV_FRAMER_CHECKSUM_EN
  ,
  output logic [15:0]                frame_checksum
`endif
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CNW = AW + 1;
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CNW-1:0] CNT_FULL = CNW'(FIFO_DEPTH);
  localparam logic [CNW-1:0] CNT_ACC  = CNW'(FIFO_DEPTH - 3);

  typedef enum logic [2:0] {IDLE, TOP, ROW_L, ROW_BODY, ROW_R, BOTTOM} state_t;

  // Magnitude is formed one bit wider so |-2^(IN_WIDTH-1)| is representable and saturates.
  function automatic logic [7:0] requant(input logic signed [IN_WIDTH-1:0] r, input logic m,
                                         input logic [3:0] sh);
    logic signed [IN_WIDTH:0] rx;
    logic [IN_WIDTH:0]        v;
    rx = {r[IN_WIDTH-1], r};
    v  = r[IN_WIDTH-1] ? (m ? '0 : $unsigned(-rx)) : $unsigned(rx);
    v  = v >> sh;
    return (v > (IN_WIDTH+1)'(255)) ? 8'hff : v[7:0];
  endfunction

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [7:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNW-1:0] count_q, count_d;
  logic           in_accepting_q, in_accepting_d;
  logic           overflow_q, overflow_d;
  state_t         state_q, state_d, cur, nxt;
  logic [CW-1:0]  col_q, col_d, col_n;
  logic [RW-1:0]  row_q, row_d, row_n;
  logic [7:0]     out_pixel_q, out_pixel_d;
  logic           out_valid_q, out_valid_d;
  logic           out_sof_q, out_sof_d, out_eol_q, out_eol_d, out_eof_q, out_eof_d;
  logic           busy_q, busy_d;
  logic           wr, pop, start, load, emit, is_eol, is_eof, hs;

  always_comb begin
    wr     = in_valid && (count_q != CNT_FULL);
    start  = frame_start && !busy_q;
    // The start pulse is folded into the current state so the first TOP pixel loads on that same edge.
    cur    = (state_q == IDLE && start) ? TOP : state_q;
    load   = !out_valid_q || out_ready;
    // In the body an empty FIFO produces a bubble, never a substitute pad.
    emit   = load && (cur != IDLE) && !(cur == ROW_BODY && count_q == '0);
    pop    = emit && (cur == ROW_BODY);
    hs     = out_valid_q && out_ready;
    is_eol = (col_q == COL_LAST);
    is_eof = is_eol && (row_q == ROW_LAST);
    col_n  = is_eol ? '0 : col_q + CW'(1);
    row_n  = is_eol ? row_q + RW'(1) : row_q;
    nxt    = is_eof               ? IDLE   :
             (row_n == '0)        ? TOP    :
             (row_n == ROW_LAST)  ? BOTTOM :
             (col_n == '0)        ? ROW_L  :
             (col_n == COL_LAST)  ? ROW_R  : ROW_BODY;
    state_d = emit ? nxt : state_q;
    col_d   = emit ? col_n : col_q;
    row_d   = emit ? (is_eof ? '0 : row_n) : row_q;
    mem_d = mem_q;
    if (wr) mem_d[wr_ptr_q] = requant(in_result, mode, shift);
    wr_ptr_d       = wr_ptr_q + AW'(wr);
    rd_ptr_d       = rd_ptr_q + AW'(pop);
    count_d        = count_q + CNW'(wr) - CNW'(pop);
    in_accepting_d = (count_d <= CNT_ACC);
    overflow_d     = overflow_q || (in_valid && !wr);
    out_valid_d = load ? emit : out_valid_q;
    out_pixel_d = load ? ((cur == ROW_BODY) ? mem_q[rd_ptr_q] : PAD_VALUE) : out_pixel_q;
    out_sof_d   = load ? (emit && col_q == '0 && row_q == '0) : out_sof_q;
    out_eol_d   = load ? (emit && is_eol) : out_eol_q;
    out_eof_d   = load ? (emit && is_eof) : out_eof_q;
    busy_d      = start ? 1'b1 : (hs && out_eof_q) ? 1'b0 : busy_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q          <= '{default: '0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      in_accepting_q <= 1'b1;
      overflow_q     <= 1'b0;
      state_q        <= IDLE;
      col_q          <= '0;
      row_q          <= '0;
      out_pixel_q    <= '0;
      out_valid_q    <= 1'b0;
      out_sof_q      <= 1'b0;
      out_eol_q      <= 1'b0;
      out_eof_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      in_accepting_q <= in_accepting_d;
      overflow_q     <= overflow_d;
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      out_pixel_q    <= out_pixel_d;
      out_valid_q    <= out_valid_d;
      out_sof_q      <= out_sof_d;
      out_eol_q      <= out_eol_d;
      out_eof_q      <= out_eof_d;
      busy_q         <= busy_d;
    end
  end

  assign in_accepting = in_accepting_q;
  assign overflow     = overflow_q;
  assign out_pixel    = out_pixel_q;
  assign out_valid    = out_valid_q;
  assign out_sof      = out_sof_q;
  assign out_eol      = out_eol_q;
  assign out_eof      = out_eof_q;
  assign busy         = busy_q;

`ifdef CONV_FRAMER_CHECKSUM_EN
  logic [15:0] acc_q, acc_d, cks_q, cks_d;

  // Accumulates on every handshake; the EOF handshake publishes the total and restarts the sum.
  always_comb begin
    acc_d = hs ? (out_eof_q ? 16'd0 : acc_q + {8'd0, out_pixel_q}) : acc_q;
    cks_d = (hs && out_eof_q) ? acc_q + {8'd0, out_pixel_q} : cks_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      cks_q <= '0;
    end else begin
      acc_q <= acc_d;
      cks_q <= cks_d;
    end
  end

  assign frame_checksum = cks_q;
`endif
endmodule

// File: tb/tb_conv_out_framer.sv
// tb_conv_out_framer: scoreboard bench for conv_out_framer on a 6x6 frame.
module tb_conv_out_framer;
  localparam int W = 6;
  localparam int H = 6;
  localparam int D = 8;

  logic               clock = 0, reset = 0, frame_start = 0, mode = 0;
  logic [3:0]         shift = 0;
  logic signed [31:0] in_result = 0;
  logic               in_valid = 0, out_ready = 1;
  logic               in_accepting, out_valid, out_sof, out_eol, out_eof, busy, overflow;
  logic [7:0]         out_pixel;
`ifdef CONV_FRAMER_CHECKSUM_EN
  logic [15:0]        frame_checksum;
`endif

  conv_out_framer #(.IMG_W(W), .IMG_H(H), .IN_WIDTH(32), .FIFO_DEPTH(D), .PAD_VALUE(8'd0)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .mode(mode), .shift(shift),
    .in_result(in_result), .in_valid(in_valid), .in_accepting(in_accepting),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .busy(busy), .overflow(overflow)
`ifdef CONV_FRAMER_CHECKSUM_EN
    , .frame_checksum(frame_checksum)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {logic body; logic sof; logic eol; logic eof; logic [7:0] pix;} exp_t;

  exp_t               sb[$];
  int                 n_checks = 0, n_pass = 0;
  int                 emitted = 0, bubbles = 0, ph = 0;
  logic               toggle_en = 0, ready_lvl = 1;
  logic [7:0]         exp_int[16];
  logic signed [31:0] in_vals[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // out_ready driver: a level, or high one cycle in three
  initial forever begin
    @(posedge clock);
    #1;
    ph++;
    out_ready = toggle_en ? (ph % 3 == 0) : ready_lvl;
  end

  // monitor: pops the scoreboard on every handshake, checks stall stability and bubble placement
  initial begin
    exp_t        e;
    logic        stall = 0, bubble_pend = 0;
    logic [11:0] held = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        stall = 0;
        bubble_pend = 0;
        continue;
      end
      if (stall) check("stall_hold", {out_valid, out_sof, out_eol, out_eof, out_pixel}, held);
      if (busy && !out_valid) begin
        bubbles++;
        bubble_pend = 1;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_pixel", {out_sof, out_eol, out_eof, out_pixel}, 32'hdead);
        else begin
          e = sb.pop_front();
          check($sformatf("pixel[%0d]", emitted), {out_sof, out_eol, out_eof, out_pixel},
                {e.sof, e.eol, e.eof, e.pix});
          if (bubble_pend) check("bubble_in_body", e.body, 1);
          bubble_pend = 0;
          emitted++;
        end
      end
      stall = out_valid && !out_ready;
      held  = {out_valid, out_sof, out_eol, out_eof, out_pixel};
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        exp_t x;
        x.body = (r > 0 && r < H - 1 && c > 0 && c < W - 1);
        x.pix  = 8'd0;
        if (x.body) x.pix = exp_int[(r - 1) * (W - 2) + c - 1];
        x.sof  = (r == 0 && c == 0);
        x.eol  = (c == W - 1);
        x.eof  = (c == W - 1 && r == H - 1);
        sb.push_back(x);
      end
  endtask

  task automatic start_frame();
    push_frame();
    frame_start = 1;
    @(posedge clock);
    #1;
    frame_start = 0;
  endtask

  task automatic write1(input logic signed [31:0] v, input logic m, input logic [3:0] sh);
    mode = m;
    shift = sh;
    in_result = v;
    in_valid = 1;
    @(posedge clock);
    #1;
    in_valid = 0;
  endtask

  task automatic feed(input int first, input int n, input int gap);
    for (int i = first; i < first + n; i++) begin
      int w = 0;
      while (!in_accepting && w < 1000) begin
        @(posedge clock);
        #1;
        w++;
      end
      if (w >= 1000) check("accept_timeout", in_accepting, 1);
      in_result = in_vals[i];
      in_valid = 1;
      @(posedge clock);
      #1;
      in_valid = 0;
      repeat (gap) begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 3000) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({name, "_completed"}, (n < 3000), 1);
    check({name, "_busy_low"}, busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_accepting", in_accepting, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_flags", {out_sof, out_eol, out_eof, out_pixel}, 0);
    reset = 1;
    repeat (2) @(posedge clock);
    #1;

    // 1: abs of -5 fills the interior, border pads to 0
    for (int i = 0; i < 16; i++) begin
      in_vals[i] = -5;
      exp_int[i] = 8'd5;
    end
    start_frame();
    check("t1_first_valid", out_valid, 1);
    check("t1_first_sof", out_sof, 1);
    check("t1_busy", busy, 1);
    fork
      feed(0, 16, 0);
      wait_done("t1");
    join
`ifdef CONV_FRAMER_CHECKSUM_EN
    check("t1_checksum", frame_checksum, 16'd80);
`endif

    // 2: requant corner cases preloaded while idle, then a ramp
    write1(-7, 1, 0);
    write1(-7, 0, 0);
    write1(1000, 0, 2);
    write1(1024, 0, 2);
    write1(32'sh8000_0000, 0, 0);
    check("t2_idle_no_output", out_valid, 0);
    mode = 0;
    shift = 0;
    exp_int[0] = 8'd0;
    exp_int[1] = 8'd7;
    exp_int[2] = 8'd250;
    exp_int[3] = 8'd255;
    exp_int[4] = 8'd255;
    for (int k = 0; k < 11; k++) begin
      in_vals[k] = k * 17;
      exp_int[k + 5] = 8'(k * 17);
    end
    start_frame();
    fork
      feed(0, 11, 0);
      wait_done("t2");
    join

    // 3: test 1 content under 1-in-3 out_ready
    for (int i = 0; i < 16; i++) begin
      in_vals[i] = -5;
      exp_int[i] = 8'd5;
    end
    toggle_en = 1;
    @(posedge clock);
    #1;
    start_frame();
    fork
      feed(0, 16, 0);
      wait_done("t3");
    join
    toggle_en = 0;
    @(posedge clock);
    #1;

    // 4: starved input, one result per 10 cycles
    for (int i = 0; i < 16; i++) begin
      in_vals[i] = i + 1;
      exp_int[i] = 8'(i + 1);
    end
    bubbles = 0;
    start_frame();
    fork
      feed(0, 16, 9);
      wait_done("t4");
    join
    check("t4_bubbles_seen", (bubbles > 0), 1);

    // 5: fill FIFO with no frame running, then overrun it once
    ready_lvl = 0;
    in_valid = 1;
    for (int k = 0; k < 9; k++) begin
      in_result = (k < 8) ? k + 1 : 99;
      @(posedge clock);
      #1;
      if (k < 8) check($sformatf("t5_accepting_after_%0d", k + 1), in_accepting, (k + 1 <= D - 3));
      check($sformatf("t5_overflow_after_%0d", k + 1), overflow, (k == 8));
    end
    in_valid = 0;
    ready_lvl = 1;
    for (int i = 0; i < 16; i++) begin
      in_vals[i] = i + 1;
      exp_int[i] = 8'(i + 1);
    end
    @(posedge clock);
    #1;
    start_frame();
    fork
      feed(8, 8, 0);
      wait_done("t5");
    join
    check("t5_overflow_sticky", overflow, 1);

    // 6: reset in the middle of the first body row
    for (int v = 1; v <= 6; v++) write1(v, 0, 0);
    start_frame();
    begin
      int n = 0;
      int e0 = emitted;
      while (emitted < e0 + 8 && n < 500) begin
        @(posedge clock);
        #1;
        n++;
      end
      check("t6_reached_body", (n < 500), 1);
    end
    reset = 0;
    #1;
    sb.delete();
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_in_accepting", in_accepting, 1);
    check("t6_rst_overflow", overflow, 0);
    @(posedge clock);
    #1;
    check("t6_rst_flags", {out_sof, out_eol, out_eof, out_pixel}, 0);
    reset = 1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 16; i++) begin
      in_vals[i] = i + 21;
      exp_int[i] = 8'(i + 21);
    end
    start_frame();
    fork
      feed(0, 16, 0);
      wait_done("t6");
    join

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
